// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline defaults and control-bit bundle
// Used by every pipeline stage register, not only EX/MEM.
package pipe_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int AW_DEFAULT    = 5;

    typedef struct packed {
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - width-generic stage flop with async clear, enable and sync clear
// Synchronous clear wins over enable so a bubble can be forced into a stalled stage.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_ex_mem.sv
// rtl/pipe_ex_mem.sv - EX/MEM pipeline register, one cycle latency
// Optional STALL/FLUSH ports and behaviour under macro PIPE_EX_MEM_CTRL_EN.
module pipe_ex_mem
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPE_EX_MEM_CTRL_EN
    input  logic             STALL,
    input  logic             FLUSH,
`endif
    input  logic             MEMWRITE_IN,
    input  logic             MEMTOREG_IN,
    input  logic             REGWRITE_IN,
    input  logic [WIDTH-1:0] RESULTOP_IN,
    input  logic [WIDTH-1:0] WRDATA_IN,
    input  logic [AW-1:0]    ARD_IN,
    output logic             MEMWRITE_OUT,
    output logic             MEMTOREG_OUT,
    output logic             REGWRITE_OUT,
    output logic [WIDTH-1:0] RESULTOP_OUT,
    output logic [WIDTH-1:0] WRDATA_OUT,
    output logic [AW-1:0]    ARD_OUT
);

    logic  stage_en;
    logic  stage_clr;
    ctrl_t ctrl_in;
    ctrl_t ctrl_out;

`ifdef PIPE_EX_MEM_CTRL_EN
    // FLUSH overrides STALL: the clear path in pipe_reg beats the enable.
    assign stage_en  = ~STALL;
    assign stage_clr = FLUSH;
`else
    assign stage_en  = 1'b1;
    assign stage_clr = 1'b0;
`endif

    assign ctrl_in.memwrite = MEMWRITE_IN;
    assign ctrl_in.memtoreg = MEMTOREG_IN;
    assign ctrl_in.regwrite = REGWRITE_IN;

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk (clk),
        .rst (rst),
        .en  (stage_en),
        .clr (stage_clr),
        .d   (ctrl_in),
        .q   (ctrl_out)
    );

    pipe_reg #(.W(WIDTH)) u_result (
        .clk (clk),
        .rst (rst),
        .en  (stage_en),
        .clr (stage_clr),
        .d   (RESULTOP_IN),
        .q   (RESULTOP_OUT)
    );

    pipe_reg #(.W(WIDTH)) u_wrdata (
        .clk (clk),
        .rst (rst),
        .en  (stage_en),
        .clr (stage_clr),
        .d   (WRDATA_IN),
        .q   (WRDATA_OUT)
    );

    pipe_reg #(.W(AW)) u_ard (
        .clk (clk),
        .rst (rst),
        .en  (stage_en),
        .clr (stage_clr),
        .d   (ARD_IN),
        .q   (ARD_OUT)
    );

    assign MEMWRITE_OUT = ctrl_out.memwrite;
    assign MEMTOREG_OUT = ctrl_out.memtoreg;
    assign REGWRITE_OUT = ctrl_out.regwrite;

endmodule

// File: tb/tb_pipe_ex_mem.sv
// tb/tb_pipe_ex_mem.sv - scoreboard bench for pipe_ex_mem (STALL/FLUSH cases with PIPE_EX_MEM_CTRL_EN)
module tb_pipe_ex_mem;

    typedef struct {
        logic        mw;
        logic        mr;
        logic        rw;
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  ard;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mw_in, mr_in, rw_in;
    logic [31:0] res_in, wd_in;
    logic [4:0]  ard_in;
    logic        mw_out, mr_out, rw_out;
    logic [31:0] res_out, wd_out;
    logic [4:0]  ard_out;
`ifdef PIPE_EX_MEM_CTRL_EN
    logic        stall = 1'b0;
    logic        flush = 1'b0;
`endif

    exp_t exp_q[$];
    event chk;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ex_mem #(.WIDTH(32), .AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef PIPE_EX_MEM_CTRL_EN
        .STALL        (stall),
        .FLUSH        (flush),
`endif
        .MEMWRITE_IN  (mw_in),
        .MEMTOREG_IN  (mr_in),
        .REGWRITE_IN  (rw_in),
        .RESULTOP_IN  (res_in),
        .WRDATA_IN    (wd_in),
        .ARD_IN       (ard_in),
        .MEMWRITE_OUT (mw_out),
        .MEMTOREG_OUT (mr_out),
        .REGWRITE_OUT (rw_out),
        .RESULTOP_OUT (res_out),
        .WRDATA_OUT   (wd_out),
        .ARD_OUT      (ard_out)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation each time the outputs are sampled.
    initial begin
        exp_t e;
        forever begin
            @(chk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: actual 0 entries required 1");
            end else begin
                e = exp_q.pop_front();
                cmp({e.name, ".memwrite"}, {31'd0, mw_out}, {31'd0, e.mw});
                cmp({e.name, ".memtoreg"}, {31'd0, mr_out}, {31'd0, e.mr});
                cmp({e.name, ".regwrite"}, {31'd0, rw_out}, {31'd0, e.rw});
                cmp({e.name, ".resultop"}, res_out, e.res);
                cmp({e.name, ".wrdata"},   wd_out,  e.wd);
                cmp({e.name, ".ard"},      {27'd0, ard_out}, {27'd0, e.ard});
            end
        end
    end

    task automatic expect_now(input string nm, input logic mw, input logic mr, input logic rw,
                              input logic [31:0] res, input logic [31:0] wd, input logic [4:0] ard);
        exp_t e;
        e.mw = mw; e.mr = mr; e.rw = rw; e.res = res; e.wd = wd; e.ard = ard; e.name = nm;
        exp_q.push_back(e);
        ->chk;
        #1;
    endtask

    task automatic drive(input logic mw, input logic mr, input logic rw,
                         input logic [31:0] res, input logic [31:0] wd, input logic [4:0] ard);
        mw_in = mw; mr_in = mr; rw_in = rw; res_in = res; wd_in = wd; ard_in = ard;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F);
        #1;
        expect_now("reset_t0", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h00);
        @(posedge clk); #1;
        expect_now("reset_across_edge", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h00);

        // Release reset while clk is high; the next rising edge captures vector 1.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5555_5555, 5'b10101);
        expect_now("pre_edge_v1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h00);
        @(posedge clk); #1;
        expect_now("v1", 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5555_5555, 5'b10101);

        drive(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8765_4321, 5'b01010);
        expect_now("hold_before_v2", 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5555_5555, 5'b10101);
        @(posedge clk); #1;
        expect_now("v2", 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8765_4321, 5'b01010);

        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 5'b11111);
        @(posedge clk); #1;
        expect_now("all_ones_res", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 5'b11111);

        drive(1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h8000_0000, 5'b00000);
        @(posedge clk); #1;
        expect_now("edge_bits", 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h8000_0000, 5'b00000);

        drive(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8765_4321, 5'b01010);
        @(posedge clk); #1;
        expect_now("v2_again", 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8765_4321, 5'b01010);

        // Mid-cycle reset: clears at once, no clock edge in between.
        #1;
        rst = 1'b0;
        #1;
        expect_now("midcycle_reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h00);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'b00011);
        #1;
        expect_now("post_release_pre_edge", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h00);
        @(posedge clk); #1;
        expect_now("first_edge_after_reset", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'b00011);

        drive(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8765_4321, 5'b01010);
        @(posedge clk); #1;
        expect_now("v2_load", 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8765_4321, 5'b01010);

`ifdef PIPE_EX_MEM_CTRL_EN
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h0BAD_0BAD, 32'h1111_2222, 5'b11100);
        @(posedge clk); #1;
        expect_now("stall_hold", 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8765_4321, 5'b01010);
        @(posedge clk); #1;
        expect_now("stall_hold2", 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h8765_4321, 5'b01010);
        flush = 1'b1;
        @(posedge clk); #1;
        expect_now("flush_over_stall", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h00);
        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk); #1;
        expect_now("resume", 1'b1, 1'b1, 1'b1, 32'h0BAD_0BAD, 32'h1111_2222, 5'b11100);
        flush = 1'b1;
        @(posedge clk); #1;
        expect_now("flush_only", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h00);
        flush = 1'b0;
        stall = 1'b1;
        rst   = 1'b0;
        #1;
        expect_now("reset_over_stall", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h00);
        rst   = 1'b1;
        stall = 1'b0;
`endif

        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d entries required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
